gemm_tensor_loader: RTL and testbench
=====================================

GEMM_TENSOR_LOADER -- requirements
Module: gemm_tensor_loader

Interface
REQ-001 The block SHALL have parameter INP_WIDTH, default 8, the input element width in bits.
REQ-002 The block SHALL have parameter WGT_WIDTH, default 8, the weight element width in bits.
REQ-003 The block SHALL have parameter INP_DEPTH, default 16, the number of input elements per tensor.
REQ-004 The block SHALL have parameter WGT_DEPTH, default 256 (INP_DEPTH*INP_DEPTH), the number of weight elements per tensor.
REQ-005 The block SHALL have parameter ADDR_WIDTH, default 10, the memory address width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle load request.
REQ-009 The block SHALL have ports inp_base and wgt_base, input, ADDR_WIDTH bits each: tensor base addresses, sampled with start.
REQ-010 The block SHALL have ports inp_rd_en (output, 1) and inp_addr (output, ADDR_WIDTH): the input memory read request.
REQ-011 The block SHALL have port inp_rdata, input, INP_WIDTH bits: input memory read data, 1-cycle latency.
REQ-012 The block SHALL have ports wgt_rd_en (output, 1) and wgt_addr (output, ADDR_WIDTH): the weight memory read request.
REQ-013 The block SHALL have port wgt_rdata, input, WGT_WIDTH bits: weight memory read data, 1-cycle latency.
REQ-014 The block SHALL have port i_tensor, output, INP_WIDTH*INP_DEPTH bits: the packed input tensor for gemm_op.
REQ-015 The block SHALL have port w_tensor, output, WGT_WIDTH*WGT_DEPTH bits: the packed weight tensor for gemm_op.
REQ-016 The block SHALL have ports t_valid (output, 1) and t_ready (input, 1): the tensor handshake.
REQ-017 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 The block SHALL implement FSM states IDLE, FETCH, DRAIN and VALID.
REQ-019 IDLE SHALL move to FETCH on start=1, latching both bases and clearing the 8-bit counter cnt.
REQ-020 In FETCH the block SHALL drive wgt_rd_en=1, wgt_addr=wgt_base+cnt, inp_rd_en=(cnt<INP_DEPTH) and inp_addr=wgt-independent inp_base+cnt, with cnt incrementing each cycle.
REQ-021 FETCH SHALL move to DRAIN in the cycle after the request with cnt=WGT_DEPTH-1 is issued.
REQ-022 Read data SHALL be captured one cycle after its request into slot k = delayed cnt: w_tensor[k*WGT_WIDTH +: WGT_WIDTH] and, for k<INP_DEPTH, i_tensor[k*INP_WIDTH +: INP_WIDTH].
REQ-023 Weight slot k SHALL equal row m = k/INP_DEPTH, column n = k%INP_DEPTH (row-major).
REQ-024 DRAIN SHALL capture the last weight word and move to VALID.
REQ-025 t_valid SHALL first be 1 exactly 257 clock edges after the edge that sampled start.
REQ-026 In VALID, t_valid=1 and i_tensor/w_tensor SHALL be held stable until t_valid&t_ready, which returns the block to IDLE.
REQ-027 A start arriving outside IDLE, including in the handshake cycle, SHALL be ignored.
REQ-028 Addresses SHALL wrap modulo 2^ADDR_WIDTH.
REQ-029 Outside FETCH, both rd_en outputs SHALL be 0; read data outside capture cycles SHALL be ignored.
REQ-030 Tensor registers SHALL change only on capture cycles; stale slots persist until overwritten.

Reset
REQ-031 On rst_n=0 (asynchronous), the state SHALL become IDLE and cnt, bases, tensors, t_valid, busy, rd_en and addresses SHALL all become 0.
REQ-032 A reset mid-FETCH or mid-VALID SHALL abort immediately; there SHALL be no partial handshake after release.

Structure
REQ-033 The shared package SHALL hold the width/depth defaults and the state encoding (2-bit).
REQ-034 The block SHALL be one module with no sub-modules; capture SHALL use an indexed part-select on the delayed counter.

Verification
REQ-035 Reset check: assert rst_n=0 mid-FETCH -> all outputs 0 and state IDLE immediately; no t_valid after release without a new start.
REQ-036 Data check: inp mem[k]=k+1, wgt mem[k]=k^8'hA5, bases 0, one start -> t_valid at edge 257, i_tensor slot 15 = 8'h10, w_tensor slot 255 = 8'h5A.
REQ-037 Backpressure check: hold t_ready=0 for 20 cycles -> t_valid stays 1 with tensors unchanged; t_ready=1 -> IDLE the next cycle, busy=0.
REQ-038 Ignored-start check: pulse start at fetch cycle 100 and in the handshake cycle -> only one load, only one t_valid.
REQ-039 Wrap check: wgt_base=10'h3F0 -> wgt_addr sequence 3F0..3FF, 000..0EF; inp_rd_en high for exactly 16 cycles.

Source files
------------

// File: rtl/gemm_tensor_loader_pkg.sv
// gemm_tensor_loader_pkg
//   Shared definitions for the GEMM tensor loader: default element widths and
//   tensor depths, the load counter width and the 2-bit FSM state encoding.
package gemm_tensor_loader_pkg;

    localparam int INP_WIDTH_DEF  = 8;
    localparam int WGT_WIDTH_DEF  = 8;
    localparam int INP_DEPTH_DEF  = 16;
    localparam int WGT_DEPTH_DEF  = INP_DEPTH_DEF * INP_DEPTH_DEF;
    localparam int ADDR_WIDTH_DEF = 10;

    // Load counter width; it must be able to hold WGT_DEPTH-1.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_t;

    // Terminal count for a tensor of the given depth.
    function automatic logic [CNT_W-1:0] cnt_last(input int depth);
        return CNT_W'(depth - 1);
    endfunction

endpackage

// File: rtl/gemm_tensor_loader_if.sv
// gemm_tensor_loader_if
//   Bundles the loader's memory read ports and the tensor handshake towards
//   gemm_op.
//   master (loader side):
//     inp_rd_en/inp_addr -> input memory request,  inp_rdata <- read data
//     wgt_rd_en/wgt_addr -> weight memory request, wgt_rdata <- read data
//     i_tensor/w_tensor  -> packed tensors, t_valid -> / t_ready <- handshake
//   slave: memories and tensor consumer (directions reversed).
interface gemm_tensor_loader_if
    import gemm_tensor_loader_pkg::*;
#(
    parameter int INP_WIDTH  = INP_WIDTH_DEF,
    parameter int WGT_WIDTH  = WGT_WIDTH_DEF,
    parameter int INP_DEPTH  = INP_DEPTH_DEF,
    parameter int WGT_DEPTH  = WGT_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                            inp_rd_en;
    logic [ADDR_WIDTH-1:0]           inp_addr;
    logic [INP_WIDTH-1:0]            inp_rdata;
    logic                            wgt_rd_en;
    logic [ADDR_WIDTH-1:0]           wgt_addr;
    logic [WGT_WIDTH-1:0]            wgt_rdata;
    logic [INP_WIDTH*INP_DEPTH-1:0]  i_tensor;
    logic [WGT_WIDTH*WGT_DEPTH-1:0]  w_tensor;
    logic                            t_valid;
    logic                            t_ready;

    modport master (
        output inp_rd_en, inp_addr,
        input  inp_rdata,
        output wgt_rd_en, wgt_addr,
        input  wgt_rdata,
        output i_tensor, w_tensor, t_valid,
        input  t_ready
    );

    modport slave (
        input  inp_rd_en, inp_addr,
        output inp_rdata,
        input  wgt_rd_en, wgt_addr,
        output wgt_rdata,
        input  i_tensor, w_tensor, t_valid,
        output t_ready
    );

endinterface

// File: rtl/gemm_tensor_loader.sv
// gemm_tensor_loader
//   Fetches one input tensor (INP_DEPTH elements) and one weight tensor
//   (WGT_DEPTH elements, row-major, slot k = row k/INP_DEPTH, col
//   k%INP_DEPTH) from two 1-cycle-latency memories and presents them packed
//   to gemm_op with a valid/ready handshake.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               one-cycle load request (honoured only in IDLE)
//     inp_base, wgt_base  tensor base addresses, sampled with start
//     busy                high whenever the FSM is not in IDLE
//     bus (master)        memory read ports, packed tensors, t_valid/t_ready
module gemm_tensor_loader
    import gemm_tensor_loader_pkg::*;
#(
    parameter int INP_WIDTH  = INP_WIDTH_DEF,
    parameter int WGT_WIDTH  = WGT_WIDTH_DEF,
    parameter int INP_DEPTH  = INP_DEPTH_DEF,
    parameter int WGT_DEPTH  = WGT_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] inp_base,
    input  logic [ADDR_WIDTH-1:0] wgt_base,
    output logic                  busy,
    gemm_tensor_loader_if.master  bus
);

    localparam logic [CNT_W-1:0] WGT_LAST  = cnt_last(WGT_DEPTH);
    localparam logic [CNT_W:0]   INP_LIMIT = (CNT_W + 1)'(INP_DEPTH);
    localparam int               INP_IDX_W = (INP_DEPTH > 1) ? $clog2(INP_DEPTH) : 1;

    state_t                         state_q;
    state_t                         state_d;
    logic [CNT_W-1:0]               cnt_p0;
    logic [ADDR_WIDTH-1:0]          inp_base_q;
    logic [ADDR_WIDTH-1:0]          wgt_base_q;
    logic                           vld_p1;
    logic [CNT_W-1:0]               cnt_p1;
    logic [INP_IDX_W-1:0]           inp_slot_p1;
    logic [INP_WIDTH*INP_DEPTH-1:0] i_tensor_q;
    logic [WGT_WIDTH*WGT_DEPTH-1:0] w_tensor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        bus.t_valid   = 1'b0;
        bus.inp_rd_en = 1'b0;
        bus.inp_addr  = '0;
        bus.wgt_rd_en = 1'b0;
        bus.wgt_addr  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy          = 1'b1;
                bus.wgt_rd_en = 1'b1;
                bus.wgt_addr  = wgt_base_q + ADDR_WIDTH'(cnt_p0);
                // The input tensor is only the first INP_DEPTH words.
                bus.inp_rd_en = ({1'b0, cnt_p0} < INP_LIMIT);
                bus.inp_addr  = inp_base_q + ADDR_WIDTH'(cnt_p0);
                if (cnt_p0 == WGT_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                busy        = 1'b1;
                bus.t_valid = 1'b1;
                if (bus.t_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: request counter and latched bases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0     <= '0;
            inp_base_q <= '0;
            wgt_base_q <= '0;
        end else if (state_q == IDLE && start) begin
            cnt_p0     <= '0;
            inp_base_q <= inp_base;
            wgt_base_q <= wgt_base;
        end else if (state_q == FETCH) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // Stage p1: request tag delayed to line up with the memory read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= (state_q == FETCH);
            cnt_p1 <= cnt_p0;
        end
    end

    assign inp_slot_p1 = cnt_p1[INP_IDX_W-1:0];

    // Stage p2: capture into the tensor slot selected by the delayed counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_tensor_q <= '0;
            w_tensor_q <= '0;
        end else if (vld_p1) begin
            w_tensor_q[cnt_p1*WGT_WIDTH +: WGT_WIDTH] <= bus.wgt_rdata;
            if ({1'b0, cnt_p1} < INP_LIMIT) begin
                i_tensor_q[inp_slot_p1*INP_WIDTH +: INP_WIDTH] <= bus.inp_rdata;
            end
        end
    end

    assign bus.i_tensor = i_tensor_q;
    assign bus.w_tensor = w_tensor_q;

endmodule

// File: tb/tb_gemm_tensor_loader.sv
module tb_gemm_tensor_loader;
    import gemm_tensor_loader_pkg::*;

    localparam int IW = 8, WW = 8, ID = 16, WD = 256, AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] inp_base = '0;
    logic [AW-1:0] wgt_base = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] inp_mem [1024];
    logic [WW-1:0] wgt_mem [1024];

    gemm_tensor_loader_if #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .INP_DEPTH(ID),
                            .WGT_DEPTH(WD), .ADDR_WIDTH(AW)) bus ();

    gemm_tensor_loader #(.INP_WIDTH(IW), .WGT_WIDTH(WW), .INP_DEPTH(ID),
                         .WGT_DEPTH(WD), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .inp_base (inp_base),
        .wgt_base (wgt_base),
        .busy     (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // 1-cycle latency memories; junk data when not read so stray captures show.
    always @(posedge clk) begin
        bus.inp_rdata <= bus.inp_rd_en ? inp_mem[bus.inp_addr] : 8'hEE;
        bus.wgt_rdata <= bus.wgt_rd_en ? wgt_mem[bus.wgt_addr] : 8'hEE;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Compare every slot against the memory model at the given bases.
    task automatic check_model(input string name, input logic [AW-1:0] ib, input logic [AW-1:0] wb);
        int bad = 0;
        for (int k = 0; k < ID; k++)
            if (bus.i_tensor[k*IW +: IW] !== inp_mem[ib + AW'(k)]) bad++;
        for (int k = 0; k < WD; k++)
            if (bus.w_tensor[k*WW +: WW] !== wgt_mem[wb + AW'(k)]) bad++;
        check(name, bad, 0);
    endtask

    // Issue one load and follow it until t_valid. lat counts edges after the
    // start-sampling edge. extra >= 0 pulses a start at that fetch cycle.
    task automatic do_load(input logic [AW-1:0] ib, input logic [AW-1:0] wb, input int extra,
                           output int lat, output int n_inp, output int n_wgt, output int aerr);
        lat = -1; n_inp = 0; n_wgt = 0; aerr = 0;
        @(negedge clk);
        start = 1'b1; inp_base = ib; wgt_base = wb;
        @(posedge clk);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = (i == extra);
            inp_base = 10'h2AA; wgt_base = 10'h155;
            if (bus.wgt_rd_en) begin
                if (bus.wgt_addr !== wb + AW'(n_wgt)) aerr++;
                n_wgt++;
            end
            if (bus.inp_rd_en) begin
                if (bus.inp_addr !== ib + AW'(n_inp)) aerr++;
                n_inp++;
            end
            if (bus.t_valid) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] ib;
        logic [AW-1:0] wb;
        int            extra;
        logic [7:0]    i0, i15, w0, w255;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int lat, n_inp, n_wgt, aerr, vbad, sbad, act;
        logic [IW*ID-1:0] i_snap;
        logic [WW*WD-1:0] w_snap;

        for (int k = 0; k < 1024; k++) begin
            inp_mem[k] = 8'(k + 1);
            wgt_mem[k] = 8'(k) ^ 8'hA5;
        end
        bus.t_ready = 1'b0;

        vecs[0] = '{ib: 10'h000, wb: 10'h000, extra: -1,  i0: 8'h01, i15: 8'h10, w0: 8'hA5, w255: 8'h5A};
        vecs[1] = '{ib: 10'h010, wb: 10'h005, extra: 100, i0: 8'h11, i15: 8'h20, w0: 8'hA0, w255: 8'hA1};
        vecs[2] = '{ib: 10'h3FA, wb: 10'h3F0, extra: -1,  i0: 8'hFB, i15: 8'h0A, w0: 8'h55, w255: 8'h4A};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tvalid", bus.t_valid, 0);
        check("rst_rden", {bus.inp_rd_en, bus.wgt_rd_en}, 0);
        check("rst_addr", {bus.inp_addr, bus.wgt_addr}, 0);
        check("rst_tensor", {|bus.i_tensor, |bus.w_tensor}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            do_load(vecs[v].ib, vecs[v].wb, vecs[v].extra, lat, n_inp, n_wgt, aerr);
            check($sformatf("v%0d_latency", v), lat, 257);
            check($sformatf("v%0d_inp_reads", v), n_inp, 16);
            check($sformatf("v%0d_wgt_reads", v), n_wgt, 256);
            check($sformatf("v%0d_addr_seq", v), aerr, 0);
            check($sformatf("v%0d_i_slot0", v), bus.i_tensor[0 +: 8], vecs[v].i0);
            check($sformatf("v%0d_i_slot15", v), bus.i_tensor[15*8 +: 8], vecs[v].i15);
            check($sformatf("v%0d_w_slot0", v), bus.w_tensor[0 +: 8], vecs[v].w0);
            check($sformatf("v%0d_w_slot255", v), bus.w_tensor[255*8 +: 8], vecs[v].w255);
            check_model($sformatf("v%0d_model", v), vecs[v].ib, vecs[v].wb);

            // Backpressure: hold t_ready low, tensors must not move.
            i_snap = bus.i_tensor; w_snap = bus.w_tensor;
            vbad = 0; sbad = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.t_valid !== 1'b1) vbad++;
                if (bus.i_tensor !== i_snap || bus.w_tensor !== w_snap) sbad++;
            end
            check($sformatf("v%0d_hold_valid", v), vbad, 0);
            check($sformatf("v%0d_hold_stable", v), sbad, 0);

            // Handshake with a simultaneous start, which must be ignored.
            bus.t_ready = 1'b1; start = 1'b1;
            @(negedge clk);
            bus.t_ready = 1'b0; start = 1'b0;
            check($sformatf("v%0d_post_busy", v), busy, 0);
            check($sformatf("v%0d_post_tvalid", v), bus.t_valid, 0);
            act = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy || bus.t_valid || bus.inp_rd_en || bus.wgt_rd_en) act++;
            end
            check($sformatf("v%0d_idle_quiet", v), act, 0);
            check($sformatf("v%0d_keep_tensor", v),
                  {31'b0, (bus.i_tensor === i_snap && bus.w_tensor === w_snap)}, 1);
        end

        // Reset mid-FETCH: outputs clear at once, no handshake afterwards.
        @(negedge clk);
        start = 1'b1; inp_base = '0; wgt_base = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check("midfetch_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midfetch_busy", busy, 0);
        check("midfetch_rden", {bus.inp_rd_en, bus.wgt_rd_en}, 0);
        check("midfetch_addr", {bus.inp_addr, bus.wgt_addr}, 0);
        check("midfetch_tensor", {|bus.i_tensor, |bus.w_tensor}, 0);
        check("midfetch_tvalid", bus.t_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy || bus.t_valid) act++;
        end
        check("midfetch_no_resume", act, 0);

        // Reset mid-VALID: valid drops and does not return.
        do_load(10'h000, 10'h000, -1, lat, n_inp, n_wgt, aerr);
        check("midvalid_latency", lat, 257);
        rst_n = 1'b0;
        #1;
        check("midvalid_tvalid", bus.t_valid, 0);
        check("midvalid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.t_ready = 1'b1;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || bus.t_valid) act++;
        end
        check("midvalid_no_resume", act, 0);
        bus.t_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
